kbd_scan: RTL and testbench
===========================

# kbd_scan

Keyboard matrix scanner for the PC-8001 keyboard I/O ports. It sits directly downstream of the USB keyboard processor's dual-port key RAM, on the read side, in the CPU clock domain. It sweeps the RAM rows continuously and debounces whole-frame snapshots, so a USB bank flip never produces a torn frame. It presents the committed matrix to the Z80 I/O read path as active-low row bytes on ports 00h–0Fh.

## Interface
- `ROWS`, 10: number of matrix rows scanned, 1..16.
- `DEBOUNCE`, 2: consecutive identical sweeps required before commit, 1..15.
- `SCAN_GAP`, 0: idle cycles inserted between sweeps, 0..255.
- `clk` input 1: CPU-side clock, 14.318 MHz; the same clock that drives the key RAM read port.
- `reset` input 1: synchronous, active-high.
- `kbd_adr` output 4: row address to the key RAM read port.
- `kbd_data` input 8: row byte from the key RAM. Bit = 1 means pressed. Valid 1 cycle after `kbd_adr`.
- `io_adr` input 8: CPU I/O address.
- `io_rd` input 1: one-cycle I/O read strobe.
- `io_data` output 8: registered read data, active-low (0 = pressed).
- `io_hit` output 1: one-cycle pulse; `io_data` is valid for an accepted port read.
- `key_event` output 1: one-cycle pulse when a commit changes the visible matrix.
- `any_key` output 1: OR of all committed bits.

## Operation
- Storage holds three row arrays, each `ROWS` × 8 bits:
  - `shadow`: the current sweep.
  - `cand`: the previous sweep.
  - `matrix`: the committed matrix, visible to the CPU.
- FSM states: S_ADDR, S_CAPT, S_EVAL, S_GAP.
  - S_ADDR: drive `kbd_adr = row`, go to S_CAPT.
  - S_CAPT: `shadow[row] <= kbd_data`. Set `diff` if `kbd_data != cand[row]`. If `row == ROWS-1`, go to S_EVAL; otherwise `row++` and go to S_ADDR.
  - S_EVAL, with `diff = 0`: `stable` is incremented, saturating at 15.
  - S_EVAL, with `diff = 1`: `cand <= shadow` (`cand[ROWS-1]` takes the value just captured) and `stable <= 1`.
  - S_EVAL, commit: if `stable_next >= DEBOUNCE` and `cand_next != matrix`, then `matrix <= cand_next` and pulse `key_event`.
  - S_EVAL, exit: clear `diff` and `row`. Go to S_GAP if `SCAN_GAP > 0`, else S_ADDR.
  - S_GAP: count `SCAN_GAP` cycles, then go to S_ADDR.
- A commit replaces the whole `matrix` in one cycle. Partial updates never happen.
- CPU read: a port read is accepted when `io_rd` is high and `io_adr[7:4] == 0`.
  - Rows with `io_adr[3:0] < ROWS` return `io_data <= ~matrix[io_adr[3:0]]`.
  - Rows `>= ROWS` return 8'hFF.
  - `io_hit` pulses on every accepted read.
  - With `io_rd` high and any other address, `io_data` holds its value and there is no `io_hit`.
- `any_key` is registered and updated on commit.

## Timing
- Reset values:
  - `kbd_adr` = 0, `io_data` = 8'hFF, `io_hit` = 0, `key_event` = 0, `any_key` = 0.
  - `shadow`, `cand` and `matrix` are all zero; `stable` = 0; `diff` = 0.
  - FSM in S_ADDR with `row` = 0.
- Sweep period is `2*ROWS + 1 + SCAN_GAP` cycles (21 cycles at the defaults).
- Key-press latency from a RAM change to `key_event` is at most `(DEBOUNCE+1)` sweeps + 1 cycle.
- I/O read latency: `io_data` and `io_hit` are valid in the cycle after `io_rd`.
- A read in the same cycle as a commit returns the pre-commit `matrix`.
- `io_rd` held for multiple cycles produces one read per cycle and is never blocked by scanning.
- Reset asserted mid-sweep: the partial sweep is discarded, and `shadow`, `cand` and `matrix` are cleared. A key held through reset needs a full debounce before it reappears.
- `DEBOUNCE = 1`: commit on every sweep whose content differs from `matrix`.
- `stable` saturates at 15 and never wraps.

## Structure
- Shared package `kbd_pkg` holds:
  - the FSM state encoding;
  - `KBD_IO_BASE` = 4'h0, the high nibble of the port address;
  - `KBD_MAX_ROWS` = 16;
  - the active-low convention constant `KBD_IDLE_ROW` = 8'hFF.
- One sub-module, `kbd_row_file`, holds the three arrays. Its interface is:
  - a write port for `shadow`;
  - a whole-array copy `shadow→cand` and `cand→matrix`;
  - a combinational read of `cand[row]` for the compare;
  - a registered CPU read of `matrix`.
- The FSM, counters and I/O decode live in `kbd_scan`.

## Test plan
- Reset, then read port 00h → `io_data` = FF and `io_hit` = 1 one cycle later; `key_event` stays 0 for 10 sweeps with an all-zero RAM.
- RAM row 3 = 8'h04 held steady → exactly one `key_event` after the 3rd sweep's S_EVAL; read 03h → F B; `any_key` = 1.
- Row 3 toggles 04/00 every sweep with DEBOUNCE = 2 → no commit, port 03h stays FF.
- Read port 0Ch (beyond ROWS = 10) → FF; read port 23h → no `io_hit`, `io_data` unchanged.
- `io_rd` to 05h in the same cycle as a commit changing row 5 from 00 to 01 → FF returned, and the next read returns FE.
- Reset pulsed at row 6 of a sweep with keys committed → all outputs return to reset values the next cycle; the scan restarts at `kbd_adr` = 0.

Source files
------------

// File: rtl/kbd_scan_pkg.sv
// ============================================================================
// kbd_pkg : shared FSM encoding and constants for the PC-8001 keyboard scanner
// Rev 1.0
// ============================================================================
`default_nettype none

package kbd_pkg;

    typedef enum logic [1:0] {
        S_ADDR = 2'd0,
        S_CAPT = 2'd1,
        S_EVAL = 2'd2,
        S_GAP  = 2'd3
    } kbd_state_e;

    localparam logic [3:0] KBD_IO_BASE    = 4'h0;
    localparam int         KBD_MAX_ROWS   = 16;
    localparam logic [7:0] KBD_IDLE_ROW   = 8'hFF;
    localparam logic [3:0] KBD_STABLE_MAX = 4'd15;

    // Sweep-stability counter never wraps; a wrap would re-arm debounce.
    function automatic logic [3:0] kbd_sat_inc(input logic [3:0] v);
        return (v == KBD_STABLE_MAX) ? v : v + 4'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/kbd_scan_if.sv
// ============================================================================
// kbd_scan_if : Z80 I/O read bus between CPU (master) and keyboard scanner
// Rev 1.0
// ============================================================================
`default_nettype none

interface kbd_scan_if;
    logic [7:0] io_adr;
    logic       io_rd;
    logic [7:0] io_data;
    logic       io_hit;

    modport master (output io_adr, output io_rd, input io_data, input io_hit);
    modport slave  (input io_adr, input io_rd, output io_data, output io_hit);
endinterface

`default_nettype wire

// File: rtl/kbd_row_file.sv
// ============================================================================
// kbd_row_file : shadow / candidate / committed row arrays of the scanner
// Rev 1.0
// ============================================================================
`default_nettype none

module kbd_row_file
    import kbd_pkg::*;
#(
    parameter int ROWS = 10
) (
    input  wire logic       clk,
    input  wire logic       reset,
    input  wire logic       i_sh_we,
    input  wire logic [3:0] i_sh_row,
    input  wire logic [7:0] i_sh_data,
    input  wire logic       i_cand_load,
    input  wire logic       i_commit,
    input  wire logic [3:0] i_cand_row,
    output logic      [7:0] o_cand_data,
    output logic            o_next_differs,
    output logic            o_next_any,
    input  wire logic       i_rd_en,
    input  wire logic [3:0] i_rd_row,
    output logic      [7:0] o_rd_data
);

    logic [7:0] r_shadow [ROWS];
    logic [7:0] r_cand   [ROWS];
    logic [7:0] r_matrix [ROWS];
    logic [7:0] r_rd_data;
    logic [7:0] w_next   [ROWS];
    logic       w_differs;
    logic       w_any;
    logic       w_rd_in_range;

    // cand_next: the candidate as it will be after this cycle's load
    for (genvar g = 0; g < ROWS; g++) begin : g_next
        assign w_next[g] = i_cand_load ? r_shadow[g] : r_cand[g];
    end

    always_comb begin
        w_differs = 1'b0;
        w_any     = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            if (w_next[r] != r_matrix[r]) begin
                w_differs = 1'b1;
            end
            w_any = w_any | (|w_next[r]);
        end
    end

    assign w_rd_in_range  = ({1'b0, i_rd_row} < 5'(ROWS));
    assign o_cand_data    = r_cand[i_cand_row];
    assign o_next_differs = w_differs;
    assign o_next_any     = w_any;
    assign o_rd_data      = r_rd_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < ROWS; r++) begin
                r_shadow[r] <= '0;
                r_cand[r]   <= '0;
                r_matrix[r] <= '0;
            end
            r_rd_data <= KBD_IDLE_ROW;
        end else begin
            if (i_sh_we) begin
                r_shadow[i_sh_row] <= i_sh_data;
            end
            if (i_cand_load) begin
                r_cand <= r_shadow;
            end
            if (i_commit) begin
                r_matrix <= w_next;
            end
            // Reads see the pre-commit matrix when they coincide with a commit.
            if (i_rd_en) begin
                r_rd_data <= w_rd_in_range ? ~r_matrix[i_rd_row] : KBD_IDLE_ROW;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/kbd_scan.sv
// ============================================================================
// kbd_scan : PC-8001 keyboard matrix scanner with whole-frame debounce
// Rev 1.0
// ============================================================================
`default_nettype none

module kbd_scan
    import kbd_pkg::*;
#(
    parameter int ROWS     = 10,
    parameter int DEBOUNCE = 2,
    parameter int SCAN_GAP = 0
) (
    input  wire logic       clk,
    input  wire logic       reset,
    output logic      [3:0] kbd_adr,
    input  wire logic [7:0] kbd_data,
    kbd_scan_if.slave       io,
    output logic            key_event,
    output logic            any_key
);

    localparam logic [3:0] c_last_row = 4'(ROWS - 1);
    localparam logic [3:0] c_debounce = 4'(DEBOUNCE);
    localparam logic [7:0] c_gap_last = (SCAN_GAP > 0) ? 8'(SCAN_GAP - 1) : 8'd0;

    kbd_state_e r_state, w_state_nx;
    logic [3:0] r_row, w_row_nx;
    logic       r_diff, w_diff_nx;
    logic [3:0] r_stable, w_stable_nx;
    logic [7:0] r_gap, w_gap_nx;
    logic       r_key_event, w_key_event_nx;
    logic       r_any_key;
    logic       r_io_hit;

    logic       w_sh_we;
    logic       w_cand_load;
    logic       w_commit;
    logic [7:0] w_cand_row;
    logic       w_next_differs;
    logic       w_next_any;
    logic       w_io_acc;
    logic [7:0] w_rd_data;

    // Kept outside the FSM process so the row-file compare feeds it acyclically.
    assign w_cand_load = (r_state == S_EVAL) && r_diff;
    assign w_io_acc    = io.io_rd && (io.io_adr[7:4] == KBD_IO_BASE);

    kbd_row_file #(.ROWS(ROWS)) u_rows (
        .clk            (clk),
        .reset          (reset),
        .i_sh_we        (w_sh_we),
        .i_sh_row       (r_row),
        .i_sh_data      (kbd_data),
        .i_cand_load    (w_cand_load),
        .i_commit       (w_commit),
        .i_cand_row     (r_row),
        .o_cand_data    (w_cand_row),
        .o_next_differs (w_next_differs),
        .o_next_any     (w_next_any),
        .i_rd_en        (w_io_acc),
        .i_rd_row       (io.io_adr[3:0]),
        .o_rd_data      (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_ADDR;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx     = r_state;
        w_row_nx       = r_row;
        w_diff_nx      = r_diff;
        w_stable_nx    = r_stable;
        w_gap_nx       = r_gap;
        w_sh_we        = 1'b0;
        w_commit       = 1'b0;
        w_key_event_nx = 1'b0;
        case (r_state)
            S_ADDR: begin
                w_state_nx = S_CAPT;
            end
            S_CAPT: begin
                w_sh_we = 1'b1;
                if (kbd_data != w_cand_row) begin
                    w_diff_nx = 1'b1;
                end
                if (r_row == c_last_row) begin
                    w_state_nx = S_EVAL;
                end else begin
                    w_row_nx   = r_row + 4'd1;
                    w_state_nx = S_ADDR;
                end
            end
            S_EVAL: begin
                w_stable_nx = r_diff ? 4'd1 : kbd_sat_inc(r_stable);
                if ((w_stable_nx >= c_debounce) && w_next_differs) begin
                    w_commit       = 1'b1;
                    w_key_event_nx = 1'b1;
                end
                w_diff_nx  = 1'b0;
                w_row_nx   = 4'd0;
                w_gap_nx   = 8'd0;
                w_state_nx = (SCAN_GAP > 0) ? S_GAP : S_ADDR;
            end
            S_GAP: begin
                if (r_gap == c_gap_last) begin
                    w_gap_nx   = 8'd0;
                    w_state_nx = S_ADDR;
                end else begin
                    w_gap_nx = r_gap + 8'd1;
                end
            end
            default: begin
                w_state_nx = S_ADDR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_row       <= 4'd0;
            r_diff      <= 1'b0;
            r_stable    <= 4'd0;
            r_gap       <= 8'd0;
            r_key_event <= 1'b0;
            r_any_key   <= 1'b0;
            r_io_hit    <= 1'b0;
        end else begin
            r_row       <= w_row_nx;
            r_diff      <= w_diff_nx;
            r_stable    <= w_stable_nx;
            r_gap       <= w_gap_nx;
            r_key_event <= w_key_event_nx;
            r_io_hit    <= w_io_acc;
            if (w_commit) begin
                r_any_key <= w_next_any;
            end
        end
    end

    assign kbd_adr    = r_row;
    assign key_event  = r_key_event;
    assign any_key    = r_any_key;
    assign io.io_hit  = r_io_hit;
    assign io.io_data = w_rd_data;

endmodule

`default_nettype wire

// File: tb/tb_kbd_scan.sv
// ============================================================================
// tb_kbd_scan : self-checking bench for kbd_scan (read scoreboard + vector table)
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_kbd_scan;
    import kbd_pkg::*;

    localparam int ROWS     = 10;
    localparam int DEBOUNCE = 2;
    localparam int SCAN_GAP = 0;
    localparam int SWEEP    = 2 * ROWS + 1 + SCAN_GAP;

    typedef struct {
        logic       hit;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        logic [7:0] adr;
        logic       hit;
        logic [7:0] data;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] kbd_adr;
    logic [7:0] kbd_data = 8'h00;
    logic       key_event;
    logic       any_key;
    logic [7:0] ram [16];

    int   checks = 0;
    int   errors = 0;
    int   ev_cnt = 0;
    int   ev_base;
    exp_t sb [$];
    vec_t tv [9];

    kbd_scan_if io ();

    kbd_scan #(
        .ROWS     (ROWS),
        .DEBOUNCE (DEBOUNCE),
        .SCAN_GAP (SCAN_GAP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .kbd_adr   (kbd_adr),
        .kbd_data  (kbd_data),
        .io        (io),
        .key_event (key_event),
        .any_key   (any_key)
    );

    always #5 clk = ~clk;

    always @(posedge clk) kbd_data <= ram[kbd_adr];

    always @(posedge clk) begin
        #1;
        if (key_event === 1'b1) ev_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s timeout waiting for DUT", name);
    endtask

    // Read results are checked one cycle after the strobe is sampled.
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("io_hit", 32'(io.io_hit), 32'(e.hit));
            chk("io_data", 32'(io.io_data), 32'(e.data));
        end
    end

    task automatic issue_read(input logic [7:0] adr, input logic hit, input logic [7:0] data);
        exp_t e;
        e.hit  = hit;
        e.data = data;
        io.io_adr = adr;
        io.io_rd  = 1'b1;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_adr(input logic [3:0] v, input string name);
        int n = 0;
        while (kbd_adr !== v && n < 3 * SWEEP) begin
            @(negedge clk);
            n++;
        end
        if (kbd_adr !== v) timeout(name);
    endtask

    // Returns at the negedge inside the next S_EVAL cycle (third cycle on the last row).
    task automatic wait_eval(input string name);
        int run = 0;
        int n   = 0;
        while (run < 3 && n < 3 * SWEEP) begin
            @(negedge clk);
            n++;
            if (kbd_adr === 4'(ROWS - 1)) run++;
            else run = 0;
        end
        if (run < 3) timeout(name);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0] = '{8'h00, 1'b1, 8'hFF};
        tv[1] = '{8'h03, 1'b1, 8'hFB};
        tv[2] = '{8'h23, 1'b0, 8'hFB};
        tv[3] = '{8'h09, 1'b1, 8'hFF};
        tv[4] = '{8'h0C, 1'b1, 8'hFF};
        tv[5] = '{8'h13, 1'b0, 8'hFF};
        tv[6] = '{8'h0F, 1'b1, 8'hFF};
        tv[7] = '{8'h03, 1'b1, 8'hFB};
        tv[8] = '{8'hF3, 1'b0, 8'hFB};
        for (int i = 0; i < 16; i++) ram[i] = 8'h00;
        io.io_adr = 8'h00;
        io.io_rd  = 1'b0;

        // Reset values and first read
        repeat (3) @(negedge clk);
        chk("rst_kbd_adr", 32'(kbd_adr), 32'h0);
        chk("rst_io_data", 32'(io.io_data), 32'hFF);
        chk("rst_io_hit", 32'(io.io_hit), 32'h0);
        chk("rst_key_event", 32'(key_event), 32'h0);
        chk("rst_any_key", 32'(any_key), 32'h0);
        reset = 1'b0;
        issue_read(8'h00, 1'b1, 8'hFF);
        io.io_rd = 1'b0;
        ev_base = ev_cnt;
        repeat (10 * SWEEP) @(negedge clk);
        chk("idle_no_event", 32'(ev_cnt - ev_base), 32'h0);

        // Steady press on row 3, introduced after row 3 of the first sweep
        do_reset();
        ev_base = ev_cnt;
        wait_adr(4'd5, "press_phase");
        ram[3] = 8'h04;
        wait_eval("press_eval1");
        wait_eval("press_eval2");
        wait_eval("press_eval3");
        chk("press_before_evt", 32'(key_event), 32'h0);
        @(negedge clk);
        chk("press_key_event", 32'(key_event), 32'h1);
        chk("press_any_key", 32'(any_key), 32'h1);
        repeat (3 * SWEEP) @(negedge clk);
        chk("press_event_count", 32'(ev_cnt - ev_base), 32'h1);

        // Port decode table against committed row 3 = 04
        for (int i = 0; i < 9; i++) issue_read(tv[i].adr, tv[i].hit, tv[i].data);
        io.io_rd = 1'b0;

        // Row 3 toggling every sweep never becomes stable
        ram[3] = 8'h00;
        do_reset();
        ev_base = ev_cnt;
        for (int i = 0; i < 10; i++) begin
            wait_adr(4'd7, "toggle_phase");
            ram[3] = ram[3] ^ 8'h04;
            wait_adr(4'd8, "toggle_next");
        end
        chk("toggle_no_event", 32'(ev_cnt - ev_base), 32'h0);
        issue_read(8'h03, 1'b1, 8'hFF);
        io.io_rd = 1'b0;

        // Read coinciding with the commit of row 5 sees the old matrix
        ram[3] = 8'h00;
        do_reset();
        ram[5] = 8'h01;
        ev_base = ev_cnt;
        wait_eval("coll_eval1");
        wait_eval("coll_eval2");
        issue_read(8'h05, 1'b1, 8'hFF);
        issue_read(8'h05, 1'b1, 8'hFE);
        io.io_rd = 1'b0;
        chk("coll_event", 32'(ev_cnt - ev_base), 32'h1);

        // Reset in the middle of a sweep with a key committed
        wait_adr(4'd6, "midrst_phase");
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_kbd_adr", 32'(kbd_adr), 32'h0);
        chk("midrst_io_data", 32'(io.io_data), 32'hFF);
        chk("midrst_io_hit", 32'(io.io_hit), 32'h0);
        chk("midrst_key_event", 32'(key_event), 32'h0);
        chk("midrst_any_key", 32'(any_key), 32'h0);
        reset = 1'b0;
        ev_base = ev_cnt;
        wait_eval("midrst_eval1");
        issue_read(8'h05, 1'b1, 8'hFF);
        io.io_rd = 1'b0;
        chk("midrst_no_early", 32'(ev_cnt - ev_base), 32'h0);
        wait_eval("midrst_eval2");
        @(negedge clk);
        chk("midrst_recommit", 32'(key_event), 32'h1);
        chk("midrst_any_key2", 32'(any_key), 32'h1);

        repeat (3) @(negedge clk);
        if (sb.size() != 0) timeout("scoreboard_drain");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
